// File: rtl/sample_seq_pkg.sv
// sample_seq_pkg: shared state encoding, default sizing and counter widths for the sample sequencer
package sample_seq_pkg;
   localparam int NUM_CH_DEF = 8;
   localparam int OSR_MAX_DEF = 8;
   localparam int DIV_W = 12;
   localparam int TICK_W = 4;
   localparam int P2_W = 10;
   localparam int CONV_W = 9;
   localparam int OSR_W = 4;
   typedef enum logic [1:0] {IDLE, P1, P2} state_t;
   function automatic logic [OSR_W-1:0] clamp_osr(input logic [OSR_W-1:0] osr, input int lim);
      return (int'(osr) > lim) ? OSR_W'(lim) : osr;
   endfunction
endpackage

// File: rtl/sample_sequencer_if.sv
// sample_sequencer_if: enable/config inputs and phase/strobe outputs of the sample sequencer
interface sample_sequencer_if
   import sample_seq_pkg::*;
#(
   parameter int NUM_CH = NUM_CH_DEF
);
   logic ENSAMP_sync;
   logic [DIV_W-1:0] PHASE1DIV1;
   logic [TICK_W-1:0] PHASE1COUNT;
   logic [P2_W-1:0] PHASE2COUNT;
   logic [NUM_CH-1:0] CHEN;
   logic [OSR_W-1:0] ADCOSR;
   logic PHASE1;
   logic PHASE2;
   logic ADC_START;
   logic [$clog2(NUM_CH)-1:0] CH_SEL;
   logic SAMPLE_VALID;
   logic FRAME_END;
   logic BUSY;
   modport master (
      output ENSAMP_sync, PHASE1DIV1, PHASE1COUNT, PHASE2COUNT, CHEN, ADCOSR,
      input PHASE1, PHASE2, ADC_START, CH_SEL, SAMPLE_VALID, FRAME_END, BUSY
   );
   modport slave (
      input ENSAMP_sync, PHASE1DIV1, PHASE1COUNT, PHASE2COUNT, CHEN, ADCOSR,
      output PHASE1, PHASE2, ADC_START, CH_SEL, SAMPLE_VALID, FRAME_END, BUSY
   );
endinterface

// File: rtl/seq_next_ch.sv
// seq_next_ch: next enabled channel strictly above cur, wrapping to the lowest enabled one
module seq_next_ch #(
   parameter int NUM_CH = 8
) (
   input logic [NUM_CH-1:0] mask,
   input logic [$clog2(NUM_CH)-1:0] cur,
   output logic [$clog2(NUM_CH)-1:0] nxt,
   output logic wrap
);
   localparam int CW = $clog2(NUM_CH);
   always_comb begin
      nxt = '0;
      wrap = 1'b1;
      for (int i = NUM_CH - 1; i >= 0; i--)
         if (mask[i]) nxt = CW'(i);
      for (int i = NUM_CH - 1; i >= 0; i--)
         if (mask[i] && i > int'(cur)) begin
            nxt = CW'(i);
            wrap = 1'b0;
         end
   end
endmodule

// File: rtl/sample_sequencer.sv
// sample_sequencer: two-phase AFE/ADC acquisition sequencer walking the enabled channels.
// Outputs are registered decodes of the current sequencer state, one cycle behind it.
module sample_sequencer
   import sample_seq_pkg::*;
#(
   parameter int NUM_CH = NUM_CH_DEF,
   parameter int OSR_MAX = OSR_MAX_DEF
) (
   input logic HF_CLK,
   input logic RST,
   sample_sequencer_if.slave sif
);
   localparam int CW = $clog2(NUM_CH);
   state_t state, state_n;
   logic [DIV_W-1:0] div_cnt, div_q;
   logic [TICK_W-1:0] tick_cnt, p1c_q;
   logic [P2_W-1:0] p2_cnt, p2c_q;
   logic [CONV_W-1:0] conv_cnt;
   logic [NUM_CH-1:0] chen_q;
   logic [OSR_W-1:0] osr_q;
   logic [1:0] tail;
   logic [CW-1:0] ch, nxt_ch;
   logic wrap, frm;
   logic start, tick, p1_done, p2_done, conv_done;

   // in IDLE the finder searches above the top index, which yields the lowest enabled channel
   seq_next_ch #(.NUM_CH(NUM_CH)) u_next (
      .mask(state == IDLE ? sif.CHEN : chen_q),
      .cur(state == IDLE ? CW'(NUM_CH - 1) : ch),
      .nxt(nxt_ch),
      .wrap(wrap)
   );

   always_comb begin
      start = state == IDLE && sif.ENSAMP_sync && |sif.CHEN;
      tick = div_cnt == div_q;
      p1_done = state == P1 && tail == 2'd0 && tick && tick_cnt == p1c_q;
      p2_done = state == P2 && p2_cnt == p2c_q;
      conv_done = conv_cnt == CONV_W'((1 << osr_q) - 1);
      state_n = !sif.ENSAMP_sync ? IDLE : start ? P1 : p1_done ? P2 : p2_done ? P1 : state;
   end

   always_ff @(posedge HF_CLK or posedge RST)
      if (RST) state <= IDLE;
      else state <= state_n;

   // tail counts the sample-valid cycle (2) and the channel-advance cycle (1) between channels
   always_ff @(posedge HF_CLK or posedge RST) begin
      if (RST) begin
         {div_q, p1c_q, p2c_q, chen_q, osr_q} <= '0;
         {div_cnt, tick_cnt, p2_cnt, conv_cnt, tail} <= '0;
         ch <= '0;
         frm <= 1'b0;
      end else if (!sif.ENSAMP_sync) begin
         {div_cnt, tick_cnt, p2_cnt, conv_cnt, tail} <= '0;
      end else if (start) begin
         div_q <= sif.PHASE1DIV1;
         p1c_q <= sif.PHASE1COUNT;
         p2c_q <= sif.PHASE2COUNT;
         chen_q <= sif.CHEN;
         osr_q <= clamp_osr(sif.ADCOSR, OSR_MAX);
         ch <= nxt_ch;
      end else if (state == P1 && tail != 2'd0) begin
         tail <= tail - 2'd1;
         if (tail == 2'd2) begin
            ch <= nxt_ch;
            frm <= wrap;
         end
      end else if (state == P1) begin
         div_cnt <= tick ? '0 : div_cnt + 1'b1;
         if (tick) tick_cnt <= p1_done ? '0 : tick_cnt + 1'b1;
      end else if (state == P2) begin
         p2_cnt <= p2_done ? '0 : p2_cnt + 1'b1;
         if (p2_done) begin
            conv_cnt <= conv_done ? '0 : conv_cnt + 1'b1;
            tail <= conv_done ? 2'd2 : 2'd0;
         end
      end
   end

   always_ff @(posedge HF_CLK or posedge RST) begin
      if (RST) begin
         {sif.PHASE1, sif.PHASE2, sif.ADC_START, sif.SAMPLE_VALID, sif.FRAME_END, sif.BUSY} <= '0;
         sif.CH_SEL <= '0;
      end else begin
         sif.PHASE1 <= state == P1 && tail == 2'd0;
         sif.PHASE2 <= state == P2;
         sif.ADC_START <= state == P2 && p2_cnt == '0;
         sif.SAMPLE_VALID <= state == P1 && tail == 2'd2;
         sif.FRAME_END <= state == P1 && tail == 2'd1 && frm;
         sif.BUSY <= state != IDLE;
         sif.CH_SEL <= ch;
      end
   end
endmodule

// File: tb/tb_sample_sequencer.sv
// tb_sample_sequencer: vector table, directed corner cases and randomized runs,
// all cross-checked each cycle against a frame-position model of the sequencer.
module tb_sample_sequencer;
   logic HF_CLK = 1'b0;
   logic RST = 1'b0;
   int n_vec = 0;
   int n_miss = 0;

   sample_sequencer_if #(.NUM_CH(8)) sif ();
   sample_sequencer #(.NUM_CH(8), .OSR_MAX(8)) dut (.HF_CLK(HF_CLK), .RST(RST), .sif(sif));

   always #5 HF_CLK = ~HF_CLK;

   typedef struct {
      logic [7:0] chen;
      logic [11:0] div;
      logic [3:0] p1c;
      logic [9:0] p2c;
      logic [3:0] osr;
      int ncyc;
      int p1, p2, adc, sv, fe, busy;
   } vec_t;
   vec_t tbl[5];

   // reference model: position within the current channel's slot, derived from the phase lengths
   int m_run = 0, m_t = 0, m_ch = 0, m_div = 0, m_p1c = 0, m_p2c = 0, m_osr = 0;
   int m_t1, m_c, m_n, m_l, m_u;
   logic [7:0] m_chen = '0;
   logic e_p1 = 0, e_p2 = 0, e_adc = 0, e_sv = 0, e_fe = 0, e_busy = 0;
   logic [2:0] e_ch = '0;

   function automatic int next_ch(input logic [7:0] m, input int c);
      for (int i = c + 1; i < 8; i++) if (m[i]) return i;
      for (int i = 0; i < 8; i++) if (m[i]) return i;
      return 0;
   endfunction

   always @(posedge HF_CLK or posedge RST) begin
      if (RST) begin
         m_run = 0; m_t = 0; m_ch = 0;
         {e_p1, e_p2, e_adc, e_sv, e_fe, e_busy} = '0;
         e_ch = '0;
      end else begin
         m_t1 = (m_p1c + 1) * (m_div + 1);
         m_c = m_t1 + m_p2c + 1;
         m_n = 1 << m_osr;
         m_l = m_n * m_c + 2;
         m_u = m_t % m_c;
         if (m_run != 0) begin
            e_p1 = m_t < m_n * m_c && m_u < m_t1;
            e_p2 = m_t < m_n * m_c && m_u >= m_t1;
            e_adc = m_t < m_n * m_c && m_u == m_t1;
            e_sv = m_t == m_l - 2;
            e_fe = m_t == m_l - 1 && next_ch(m_chen, m_ch) <= m_ch;
            e_busy = 1'b1;
            e_ch = 3'(m_t == m_l - 1 ? next_ch(m_chen, m_ch) : m_ch);
         end else begin
            {e_p1, e_p2, e_adc, e_sv, e_fe, e_busy} = '0;
         end
         if (!sif.ENSAMP_sync) begin
            m_run = 0; m_t = 0;
         end else if (m_run == 0) begin
            if (sif.CHEN != 0) begin
               m_run = 1; m_t = 0; m_chen = sif.CHEN;
               m_div = int'(sif.PHASE1DIV1);
               m_p1c = int'(sif.PHASE1COUNT);
               m_p2c = int'(sif.PHASE2COUNT);
               m_osr = sif.ADCOSR > 4'd8 ? 8 : int'(sif.ADCOSR);
               m_ch = next_ch(sif.CHEN, 7);
            end
         end else begin
            m_t++;
            if (m_t == m_l) begin
               m_t = 0;
               m_ch = next_ch(m_chen, m_ch);
            end
         end
      end
   end

   always @(negedge HF_CLK) begin
      n_vec++;
      if ({sif.PHASE1, sif.PHASE2, sif.ADC_START, sif.SAMPLE_VALID, sif.FRAME_END, sif.BUSY, sif.CH_SEL}
          !== {e_p1, e_p2, e_adc, e_sv, e_fe, e_busy, e_ch}) begin
         n_miss++;
         $display("FAIL cycle @%0t: got p1/p2/adc/sv/fe/busy=%b%b%b%b%b%b ch=%0d, expected %b%b%b%b%b%b ch=%0d",
                  $time, sif.PHASE1, sif.PHASE2, sif.ADC_START, sif.SAMPLE_VALID, sif.FRAME_END, sif.BUSY,
                  sif.CH_SEL, e_p1, e_p2, e_adc, e_sv, e_fe, e_busy, e_ch);
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int outs();
      return int'({sif.PHASE1, sif.PHASE2, sif.ADC_START, sif.SAMPLE_VALID, sif.FRAME_END, sif.BUSY, sif.CH_SEL});
   endfunction

   task automatic idle_then(input logic [7:0] chen, input logic [11:0] div, input logic [3:0] p1c,
                            input logic [9:0] p2c, input logic [3:0] osr);
      sif.ENSAMP_sync = 1'b0;
      repeat (3) @(negedge HF_CLK);
      sif.CHEN = chen;
      sif.PHASE1DIV1 = div;
      sif.PHASE1COUNT = p1c;
      sif.PHASE2COUNT = p2c;
      sif.ADCOSR = osr;
      sif.ENSAMP_sync = 1'b1;
   endtask

   int c_p1, c_p2, c_adc, c_sv, c_fe, c_busy, got, last_sv, fe_seen, found, sv7;
   int order[4];
   int exp_order[4] = '{2, 5, 7, 2};

   initial begin
      sif.ENSAMP_sync = 1'b0;
      sif.CHEN = '0;
      sif.PHASE1DIV1 = '0;
      sif.PHASE1COUNT = '0;
      sif.PHASE2COUNT = '0;
      sif.ADCOSR = '0;
      #1 RST = 1'b1;
      tbl[0] = '{8'h01, 12'd0, 4'd0, 10'd0, 4'd0, 20, 5, 5, 5, 5, 4, 19};
      tbl[1] = '{8'hA4, 12'd2, 4'd1, 10'd3, 4'd0, 37, 18, 12, 3, 3, 1, 36};
      tbl[2] = '{8'h00, 12'd0, 4'd0, 10'd0, 4'd0, 10, 0, 0, 0, 0, 0, 0};
      tbl[3] = '{8'h40, 12'd0, 4'd0, 10'd0, 4'd15, 515, 256, 256, 256, 1, 1, 514};
      tbl[4] = '{8'h18, 12'd1, 4'd0, 10'd1, 4'd1, 21, 8, 8, 4, 2, 1, 20};
      sif.ENSAMP_sync = 1'b1;
      sif.CHEN = 8'h01;
      repeat (3) @(negedge HF_CLK);
      chk("reset_state", outs(), 0);
      RST = 1'b0;

      idle_then(8'h01, 12'd0, 4'd0, 10'd0, 4'd0);
      @(negedge HF_CLK);
      chk("latency_edge0_busy", int'(sif.BUSY), 0);
      @(negedge HF_CLK);
      chk("latency_edge1_busy", int'(sif.BUSY), 1);
      chk("latency_edge1_phase1", int'(sif.PHASE1), 1);

      for (int v = 0; v < 5; v++) begin
         idle_then(tbl[v].chen, tbl[v].div, tbl[v].p1c, tbl[v].p2c, tbl[v].osr);
         {c_p1, c_p2, c_adc, c_sv, c_fe, c_busy} = '0;
         repeat (tbl[v].ncyc) begin
            @(negedge HF_CLK);
            c_p1 += int'(sif.PHASE1);
            c_p2 += int'(sif.PHASE2);
            c_adc += int'(sif.ADC_START);
            c_sv += int'(sif.SAMPLE_VALID);
            c_fe += int'(sif.FRAME_END);
            c_busy += int'(sif.BUSY);
         end
         chk($sformatf("vec%0d_phase1_cycles", v), c_p1, tbl[v].p1);
         chk($sformatf("vec%0d_phase2_cycles", v), c_p2, tbl[v].p2);
         chk($sformatf("vec%0d_adc_starts", v), c_adc, tbl[v].adc);
         chk($sformatf("vec%0d_sample_valids", v), c_sv, tbl[v].sv);
         chk($sformatf("vec%0d_frame_ends", v), c_fe, tbl[v].fe);
         chk($sformatf("vec%0d_busy_cycles", v), c_busy, tbl[v].busy);
      end

      idle_then(8'hA4, 12'd2, 4'd1, 10'd3, 4'd0);
      got = 0; last_sv = -1; fe_seen = 0;
      for (int k = 0; k < 200 && got < 4; k++) begin
         @(negedge HF_CLK);
         if (sif.SAMPLE_VALID) begin
            order[got] = int'(sif.CH_SEL);
            last_sv = int'(sif.CH_SEL);
            got++;
         end
         if (sif.FRAME_END && fe_seen == 0) begin
            fe_seen = 1;
            chk("frame_end_after_ch", last_sv, 7);
            chk("frame_end_ch_sel", int'(sif.CH_SEL), 2);
         end
      end
      chk("order_count", got, 4);
      chk("frame_end_seen", fe_seen, 1);
      for (int i = 0; i < got; i++) chk($sformatf("order[%0d]", i), order[i], exp_order[i]);

      idle_then(8'h2A, 12'd0, 4'd0, 10'd3, 4'd0);
      found = 0;
      for (int k = 0; k < 200 && found == 0; k++) begin
         @(negedge HF_CLK);
         if (sif.PHASE2 && sif.CH_SEL == 3'd3) found = 1;
      end
      chk("abort_reached_ch3_p2", found, 1);
      sif.ENSAMP_sync = 1'b0;
      c_sv = 0; c_fe = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge HF_CLK);
         c_sv += int'(sif.SAMPLE_VALID);
         c_fe += int'(sif.FRAME_END);
         if (k == 1) chk("abort_busy_dropped", int'(sif.BUSY), 0);
      end
      chk("abort_no_sample_valid", c_sv, 0);
      chk("abort_no_frame_end", c_fe, 0);
      sif.ENSAMP_sync = 1'b1;
      found = 0;
      for (int k = 0; k < 20 && found == 0; k++) begin
         @(negedge HF_CLK);
         if (sif.PHASE1) found = 1;
      end
      chk("abort_restart_seen", found, 1);
      chk("abort_restart_lowest", int'(sif.CH_SEL), 1);

      idle_then(8'h03, 12'd0, 4'd0, 10'd0, 4'd0);
      repeat (5) @(negedge HF_CLK);
      sif.CHEN = 8'h80;
      sif.PHASE1DIV1 = 12'd5;
      sif.PHASE2COUNT = 10'd2;
      sif.ADCOSR = 4'd3;
      c_sv = 0; sv7 = 0;
      repeat (40) begin
         @(negedge HF_CLK);
         if (sif.SAMPLE_VALID) begin
            c_sv++;
            if (sif.CH_SEL == 3'd7) sv7++;
         end
      end
      chk("midrun_sv_count", c_sv, 10);
      chk("midrun_no_ch7", sv7, 0);
      sif.ENSAMP_sync = 1'b0;
      repeat (3) @(negedge HF_CLK);
      sif.ENSAMP_sync = 1'b1;
      found = 0;
      for (int k = 0; k < 20 && found == 0; k++) begin
         @(negedge HF_CLK);
         if (sif.PHASE1) found = 1;
      end
      chk("midrun_new_mask_seen", found, 1);
      chk("midrun_new_mask_ch", int'(sif.CH_SEL), 7);

      idle_then(8'h0F, 12'd3, 4'd2, 10'd1, 4'd0);
      found = 0;
      for (int k = 0; k < 20 && found == 0; k++) begin
         @(negedge HF_CLK);
         if (sif.PHASE1) found = 1;
      end
      chk("reset_run_in_p1", found, 1);
      repeat (2) @(negedge HF_CLK);
      #2 RST = 1'b1;
      #1 chk("reset_midrun_outputs", outs(), 0);
      @(negedge HF_CLK);
      RST = 1'b0;
      @(negedge HF_CLK);
      chk("reset_release_busy", int'(sif.BUSY), 0);
      @(negedge HF_CLK);
      chk("reset_restart_phase1", int'(sif.PHASE1), 1);
      chk("reset_restart_ch", int'(sif.CH_SEL), 0);

      for (int r = 0; r < 40; r++) begin
         sif.CHEN = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         sif.PHASE1DIV1 = 12'($urandom_range(0, 3));
         sif.PHASE1COUNT = 4'($urandom_range(0, 3));
         sif.PHASE2COUNT = 10'($urandom_range(0, 7));
         sif.ADCOSR = 4'($urandom_range(0, 3));
         sif.ENSAMP_sync = 1'b1;
         repeat ($urandom_range(30, 250)) begin
            @(negedge HF_CLK);
            if ($urandom_range(0, 99) < 3) sif.ENSAMP_sync = ~sif.ENSAMP_sync;
            if ($urandom_range(0, 99) < 2) sif.CHEN = 8'($urandom);
            if ($urandom_range(0, 99) < 2) sif.PHASE2COUNT = 10'($urandom_range(0, 7));
            if ($urandom_range(0, 99) < 2) sif.ADCOSR = 4'($urandom_range(0, 3));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
